// File: rtl/bist_march_seq.sv
// March C- BIST sequencer for a single-port synchronous SRAM with registered strobes.
// Optional macro BIST_STOP_ON_FAIL_EN ends the test at the first mismatching read.
`timescale 1ns/1ps
module bist_march_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHECK, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;   // 1 = write phase of a read-write element
  logic                we_q, we_d, re_q, re_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_exp_q, rd_exp_d;
  logic                cmp_q, cmp_exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;
  logic                busy_q, done_q, pass_q;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]          fail_cnt_q, fail_cnt_d;
  logic                accept, last_addr, mismatch;

  function automatic logic is_rw(input state_e s);
    return s inside {S_M1, S_M2, S_M3, S_M4};
  endfunction

  function automatic logic is_down(input state_e s);
    return s inside {S_M3, S_M4};
  endfunction

  // Background read by each element: r1 in M2/M4, r0 elsewhere; writes are the inverse.
  function automatic logic read_bg(input state_e s);
    return s inside {S_M2, S_M4};
  endfunction

  function automatic logic write_bg(input state_e s);
    return s inside {S_M1, S_M3};
  endfunction

  function automatic state_e next_elem(input state_e s);
    case (s)
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      default: return S_M5;
    endcase
  endfunction

  assign accept    = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign last_addr = is_down(state_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);

  // The read issued last cycle is compared against its background this cycle.
  assign mismatch   = cmp_q && (mem_rdata != {DATA_W{cmp_exp_q}});
  assign fail_cnt_d  = (mismatch && fail_cnt_q != 8'hFF) ? fail_cnt_q + 8'd1 : fail_cnt_q;
  assign fail_addr_d = (mismatch && fail_cnt_q == 8'd0) ? cmp_addr_q : fail_addr_q;

`ifdef BIST_STOP_ON_FAIL_EN
  logic stop_now;
  assign stop_now = mismatch;
  assign mem_we   = we_q && !stop_now;
  assign mem_re   = re_q && !stop_now;
`else
  assign mem_we   = we_q;
  assign mem_re   = re_q;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_M0;
          addr_d  = '0;
        end
      end
      S_M0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (last_addr) begin
          state_d = next_elem(state_q);
          addr_d  = is_down(state_d) ? ADDR_MAX : '0;
        end else begin
          addr_d = is_down(state_q) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
        end
      end
      S_M5: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_CHECK;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_CHECK: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (stop_now) begin
      state_d = S_DONE;
      addr_d  = '0;
      phase_d = 1'b0;
    end
`endif
    we_d     = (state_d == S_M0) || (is_rw(state_d) && phase_d);
    re_d     = (state_d == S_M5) || (is_rw(state_d) && !phase_d);
    wdata_d  = (we_d && write_bg(state_d)) ? '1 : '0;
    rd_exp_d = read_bg(state_d);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      rd_exp_q    <= 1'b0;
      cmp_q       <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      we_q       <= we_d;
      re_q       <= re_d;
      wdata_q    <= wdata_d;
      rd_exp_q   <= rd_exp_d;
      // Track the strobe actually presented, so a suppressed read is never compared.
      cmp_q      <= mem_re;
      cmp_exp_q  <= rd_exp_q;
      cmp_addr_q <= addr_q;
      if (accept) begin
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_cnt_q  <= '0;
      end else begin
        fail_addr_q <= fail_addr_d;
        fail_cnt_q  <= fail_cnt_d;
        if (state_d == S_DONE && state_q != S_DONE) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (fail_cnt_d == 8'd0);
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_bist_march_seq.sv
// Scoreboard bench for bist_march_seq: a march-string reference model predicts every strobe
// and the final status; a negedge monitor compares them against a stuck-at-fault SRAM model.
`timescale 1ns/1ps
module tb_bist_march_seq;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, busy, done, pass;
  logic [7:0]    fail_cnt;

  always #5 clk = ~clk;

  bist_march_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_cnt(fail_cnt)
  );

  typedef struct { logic is_wr; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
  typedef struct { logic pass; logic [AW-1:0] faddr; int cnt; int cycles; } res_t;

  op_t           op_q[$];
  res_t          res_q[$];
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] mem_arr [N];
  int            n_checks = 0;
  int            n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous SRAM with per-address stuck-at masks applied to stored data.
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= (mem_wdata & ~sa0[mem_addr]) | sa1[mem_addr];
    if (mem_re) mem_rdata <= mem_arr[mem_addr];
  end

  // Reference: walk the March C- notation and predict strobes, mismatches and latency.
  task automatic plan_run();
    string         march [6];
    logic [DW-1:0] m [N];
    int            cnt = 0, nops = 0, a;
    logic [AW-1:0] fa = '0;
    bit            stopped = 0;
    byte           kind;
    logic [DW-1:0] d, seen;
    march[0] = "w0"; march[1] = "r0w1"; march[2] = "r1w0";
    march[3] = "r0w1"; march[4] = "r1w0"; march[5] = "r0";
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        for (int k = 0; k < march[e].len(); k += 2) begin
          if (!stopped) begin
            kind = march[e].getc(k);
            d    = (march[e].getc(k + 1) == "1") ? '1 : '0;
            nops++;
            if (kind == "w") begin
              op_q.push_back('{1'b1, AW'(a), d});
              m[a] = d;
            end else begin
              op_q.push_back('{1'b0, AW'(a), '0});
              seen = (m[a] & ~sa0[a]) | sa1[a];
              if (seen != d) begin
                if (cnt == 0) fa = AW'(a);
                if (cnt < 255) cnt++;
`ifdef BIST_STOP_ON_FAIL_EN
                stopped = 1;
`endif
              end
            end
          end
        end
      end
    end
    res_q.push_back('{cnt == 0, fa, cnt, nops + 2});
  endtask

  // Monitor: pops one predicted op per strobe and one predicted result per done rise.
  initial begin
    op_t  eo;
    res_t er;
    int   cyc = 0, overlap = 0, idle_strobe = 0, extra = 0;
    bit   prev_busy = 0, prev_done = 0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) cyc = 1; else cyc++;
      if (mem_we && mem_re) overlap++;
      if (!busy && (mem_we || mem_re)) idle_strobe++;
      if (mem_we || mem_re) begin
        if (op_q.size() == 0) extra++;
        else begin
          eo = op_q.pop_front();
          check("strobe kind (we)", mem_we, eo.is_wr);
          check("strobe addr", mem_addr, eo.addr);
          if (eo.is_wr) check("write data", mem_wdata, eo.data);
        end
      end
      if (done && !prev_done) begin
        check("result predicted", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          er = res_q.pop_front();
          check("pass", pass, er.pass);
          check("fail_addr", fail_addr, er.faddr);
          check("fail_cnt", fail_cnt, er.cnt);
          check("done latency", cyc, er.cycles);
        end
        check("ops left unissued", op_q.size(), 0);
        check("we/re overlap", overlap, 0);
        check("strobes while idle", idle_strobe, 0);
        check("unpredicted strobes", extra, 0);
        overlap = 0; idle_strobe = 0; extra = 0;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " mem_we"}, mem_we, 0);
    check({tag, " mem_re"}, mem_re, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " fail_addr"}, fail_addr, 0);
    check({tag, " fail_cnt"}, fail_cnt, 0);
  endtask

  // Called at #1 after a posedge; returns at #1 after the posedge following done.
  task automatic wait_done();
    int k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done within budget", done, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done held", done, 1);
    check("busy low in done", busy, 0);
  endtask

  task automatic pulse_start();
    plan_run();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, a;
    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fault-free run.
    pulse_start();
    wait_done();

    // Addr 5 bit0 stuck-at-1.
    sa1[5] = 8'h01;
    pulse_start();
    wait_done();

    // Addr 15 bit7 stuck-at-0.
    clear_faults();
    sa0[15] = 8'h80;
    pulse_start();
    wait_done();

    // Reset during the M3 read of addr 9 (cycle 93 after acceptance).
    clear_faults();
    pulse_start();
    repeat (92) begin
      @(posedge clk);
      #1;
    end
    check("pre-abort addr", mem_addr, 9);
    check("pre-abort re", mem_re, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    op_q.delete();
    res_q.delete();
    check_all_zero("abort");
    @(posedge clk);
    #1 pulse_start();
    wait_done();

    // start held through a faulty run, then re-pulsed on a clean memory.
    sa1[5] = 8'h01;
    plan_run();
    start = 1'b1;
    repeat (150) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done();
    clear_faults();
    pulse_start();
    check("restart done cleared", done, 0);
    check("restart pass cleared", pass, 0);
    check("restart fail_cnt cleared", fail_cnt, 0);
    check("restart fail_addr cleared", fail_addr, 0);
    check("restart busy", busy, 1);
    check("restart addr 0", mem_addr, 0);
    check("restart first write", mem_we, 1);
    wait_done();

    // Randomized stuck-at faults, 1..3 per run, with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      clear_faults();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | DW'(1 << $urandom_range(0, DW - 1));
        else                           sa0[a] = sa0[a] | DW'(1 << $urandom_range(0, DW - 1));
      end
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
      end
      pulse_start();
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
